// File: rtl/wb_stage_unit_pkg.sv
// Shared RISC-V writeback definitions: datapath word, writeback source select, load funct3 codes.
package RISCV_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // 2'b11 is not named: the writeback mux treats it as ALU.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_unit_load_align.sv
// Load data aligner: picks the byte/half lane from the raw memory word, extends it, flags misalignment.
module load_align
  import RISCV_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] aligned,
  output logic            misalign
);
  logic [XLEN-1:0] byte_sh, half_sh;

  assign byte_sh = mem_rdata >> {addr_lo, 3'b000};
  assign half_sh = mem_rdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    aligned  = mem_rdata;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  aligned = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      F3_LBU: aligned = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      F3_LH: begin
        aligned  = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        aligned  = {{(XLEN-16){1'b0}}, half_sh[15:0]};
        misalign = addr_lo[0];
      end
      // LW and every unassigned encoding behave as a full-word load
      default: misalign = |addr_lo;
    endcase
  end
endmodule

// File: rtl/wb_stage_unit.sv
// MEM/WB pipeline register and register-file write port driver with retire counter.
// Optional same-cycle register-file bypass toward ID when WB_BYPASS_EN is defined.
module wb_stage_unit
  import RISCV_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RET_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_4,
  input  logic                 reg_wr_4,
  input  logic [4:0]           rd_4,
  input  logic [1:0]           wb_sel_4,
  input  logic [2:0]           funct3_4,
  input  logic [1:0]           addr_lo_4,
  input  logic [XLEN-1:0]      alu_res_4,
  input  logic [XLEN-1:0]      mem_rdata_4,
  input  logic [XLEN-1:0]      pc_plus4_4,
  output logic                 valid_5,
  output logic                 wr_5,
  output logic [4:0]           rd_5,
  output logic [XLEN-1:0]      write_data_5,
  output logic                 misalign_5,
  output logic [RET_CNT_W-1:0] retire_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]           rs1_2,
  input  logic [4:0]           rs2_2,
  input  logic [XLEN-1:0]      rdat1_2,
  input  logic [XLEN-1:0]      rdat2_2,
  output logic [XLEN-1:0]      fwd1_2,
  output logic [XLEN-1:0]      fwd2_2
`endif
);
  logic [XLEN-1:0] ld_data, wb_data;
  logic            ld_mis, mis, wr_en;

  load_align #(.XLEN(XLEN)) u_align (
    .mem_rdata (mem_rdata_4),
    .funct3    (funct3_4),
    .addr_lo   (addr_lo_4),
    .aligned   (ld_data),
    .misalign  (ld_mis)
  );

  always_comb begin
    case (wb_sel_4)
      WB_MEM:  wb_data = ld_data;
      WB_PC4:  wb_data = pc_plus4_4;
      default: wb_data = alu_res_4;
    endcase
    // Alignment only matters for instructions that actually write back a load
    mis   = valid_4 && (wb_sel_4 == WB_MEM) && ld_mis;
    wr_en = valid_4 && reg_wr_4 && (rd_4 != 5'd0) && !mis;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_5      <= 1'b0;
      wr_5         <= 1'b0;
      misalign_5   <= 1'b0;
      rd_5         <= '0;
      write_data_5 <= '0;
      retire_cnt   <= '0;
    end else if (flush_i) begin
      valid_5    <= 1'b0;
      wr_5       <= 1'b0;
      misalign_5 <= 1'b0;
    end else if (!stall_i) begin
      valid_5      <= valid_4;
      wr_5         <= wr_en;
      misalign_5   <= mis;
      rd_5         <= rd_4;
      write_data_5 <= wb_data;
      if (valid_4 && !mis) retire_cnt <= retire_cnt + 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1_2 = (wr_5 && (rd_5 == rs1_2)) ? write_data_5 : rdat1_2;
  assign fwd2_2 = (wr_5 && (rd_5 == rs2_2)) ? write_data_5 : rdat2_2;
`endif
endmodule

// File: tb/tb_wb_stage_unit.sv
// Scoreboard bench for wb_stage_unit: stimulus pushes expected WB state, a monitor pops and compares.
module tb_wb_stage_unit;
  localparam int XLEN = 32;
  localparam int RCW  = 4;

  logic            clk = 1'b0, rst = 1'b1;
  logic            stall_i = 0, flush_i = 0, valid_4 = 0, reg_wr_4 = 0;
  logic [4:0]      rd_4 = 0;
  logic [1:0]      wb_sel_4 = 0, addr_lo_4 = 0;
  logic [2:0]      funct3_4 = 0;
  logic [XLEN-1:0] alu_res_4 = 0, mem_rdata_4 = 0, pc_plus4_4 = 0;
  logic            valid_5, wr_5, misalign_5;
  logic [4:0]      rd_5;
  logic [XLEN-1:0] write_data_5;
  logic [RCW-1:0]  retire_cnt;
`ifdef WB_BYPASS_EN
  logic [4:0]      rs1_2 = 0, rs2_2 = 0;
  logic [XLEN-1:0] rdat1_2 = 0, rdat2_2 = 0, fwd1_2, fwd2_2;
`endif

  wb_stage_unit #(.XLEN(XLEN), .RET_CNT_W(RCW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_4(valid_4), .reg_wr_4(reg_wr_4), .rd_4(rd_4), .wb_sel_4(wb_sel_4),
    .funct3_4(funct3_4), .addr_lo_4(addr_lo_4), .alu_res_4(alu_res_4),
    .mem_rdata_4(mem_rdata_4), .pc_plus4_4(pc_plus4_4),
    .valid_5(valid_5), .wr_5(wr_5), .rd_5(rd_5), .write_data_5(write_data_5),
    .misalign_5(misalign_5), .retire_cnt(retire_cnt)
`ifdef WB_BYPASS_EN
    , .rs1_2(rs1_2), .rs2_2(rs2_2), .rdat1_2(rdat1_2), .rdat2_2(rdat2_2),
    .fwd1_2(fwd1_2), .fwd2_2(fwd2_2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           v, w, m, chkd;
    logic [4:0]     rd;
    logic [31:0]    data;
    logic [RCW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // One MEM-stage cycle plus the hand-computed WB state expected after the next edge
  task automatic cyc(input string nm, input logic st, fl, v, rw, input logic [4:0] rd,
                     input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] alo,
                     input logic [31:0] alu, mrd, pc,
                     input logic ev, ew, input logic [4:0] erd, input logic [31:0] ed,
                     input logic em, input logic [RCW-1:0] ec, input logic chkd);
    exp_t e;
    @(negedge clk);
    stall_i = st; flush_i = fl; valid_4 = v; reg_wr_4 = rw; rd_4 = rd; wb_sel_4 = sel;
    funct3_4 = f3; addr_lo_4 = alo; alu_res_4 = alu; mem_rdata_4 = mrd; pc_plus4_4 = pc;
    e.name = nm; e.v = ev; e.w = ew; e.rd = erd; e.data = ed; e.m = em; e.cnt = ec; e.chkd = chkd;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".valid"}, 64'(valid_5), 64'(e.v));
        chk({e.name, ".wr"}, 64'(wr_5), 64'(e.w));
        chk({e.name, ".mis"}, 64'(misalign_5), 64'(e.m));
        chk({e.name, ".cnt"}, 64'(retire_cnt), 64'(e.cnt));
        if (e.chkd) begin
          chk({e.name, ".rd"}, 64'(rd_5), 64'(e.rd));
          chk({e.name, ".data"}, 64'(write_data_5), 64'(e.data));
        end
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    #1;
    chk("rst.valid", 64'(valid_5), 0); chk("rst.wr", 64'(wr_5), 0);
    chk("rst.mis", 64'(misalign_5), 0); chk("rst.rd", 64'(rd_5), 0);
    chk("rst.data", 64'(write_data_5), 0); chk("rst.cnt", 64'(retire_cnt), 0);
    @(negedge clk); rst = 1'b0;

    //  name     st fl v rw rd  sel    f3      alo alu           mrd           pc        ev ew erd data          em cnt chkd
    cyc("lb",    0, 0, 1, 1, 7, 2'b01, 3'b000, 3, 32'h0,       32'h80FF1234, 32'h0,    1, 1, 7, 32'hFFFFFF80, 0, 1, 1);
    cyc("lbu",   0, 0, 1, 1, 7, 2'b01, 3'b100, 3, 32'h0,       32'h80FF1234, 32'h0,    1, 1, 7, 32'h00000080, 0, 2, 1);
    cyc("lwmis", 0, 0, 1, 1, 9, 2'b01, 3'b010, 2, 32'h0,       32'h12345678, 32'h0,    1, 0, 9, 32'h0,        1, 2, 0);
    cyc("lhu",   0, 0, 1, 1, 10,2'b01, 3'b101, 2, 32'h0,       32'hBEEF0000, 32'h0,    1, 1, 10,32'h0000BEEF, 0, 3, 1);
    cyc("lh",    0, 0, 1, 1, 11,2'b01, 3'b001, 0, 32'h0,       32'h00008001, 32'h0,    1, 1, 11,32'hFFFF8001, 0, 4, 1);
    cyc("lhmis", 0, 0, 1, 1, 11,2'b01, 3'b001, 1, 32'h0,       32'h00008001, 32'h0,    1, 0, 11,32'h0,        1, 4, 0);
    cyc("mishld",1, 0, 1, 1, 2, 2'b00, 3'b000, 0, 32'h77,      32'h0,        32'h0,    1, 0, 11,32'h0,        1, 4, 0);
    cyc("x0",    0, 0, 1, 1, 0, 2'b00, 3'b000, 0, 32'h55,      32'h0,        32'h0,    1, 0, 0, 32'h55,       0, 5, 1);
    cyc("jal",   0, 0, 1, 1, 1, 2'b10, 3'b000, 0, 32'h9,       32'h0,        32'h104,  1, 1, 1, 32'h104,      0, 6, 1);
    cyc("sel11", 0, 0, 1, 1, 3, 2'b11, 3'b000, 0, 32'hDEADBEEF,32'h0,        32'h8,    1, 1, 3, 32'hDEADBEEF, 0, 7, 1);
    cyc("bubble",0, 0, 0, 1, 4, 2'b00, 3'b000, 0, 32'h1,       32'h0,        32'h0,    0, 0, 4, 32'h1,        0, 7, 1);
    cyc("alu",   0, 0, 1, 1, 12,2'b00, 3'b000, 0, 32'hCAFE,    32'h0,        32'h0,    1, 1, 12,32'hCAFE,     0, 8, 1);
    for (int i = 0; i < 3; i++)
      cyc("stall", 1, 0, 1, 1, 13,2'b00, 3'b000, 0, 32'h999,   32'h0,        32'h0,    1, 1, 12,32'hCAFE,     0, 8, 1);
    cyc("flush", 1, 1, 1, 1, 13,2'b00, 3'b000, 0, 32'h999,     32'h0,        32'h0,    0, 0, 0, 32'h0,        0, 8, 0);
    for (int i = 1; i <= 8; i++)
      cyc("wrap",  0, 0, 1, 1, 5'(i), 2'b00, 3'b000, 0, 32'(i*3), 32'h0,     32'h0,    1, 1, 5'(i), 32'(i*3), 0, RCW'(8+i), 1);

    // drain, then async reset between edges while wr_5 = 1
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin @(posedge clk); #2; wait_cyc++; end
    if (q.size() > 0) begin chk("drain", 64'(q.size()), 0); q.delete(); end
`ifdef WB_BYPASS_EN
    // last WB state: wr_5 = 1, rd_5 = 8, data 0x18
    rs1_2 = 5'd8; rdat1_2 = 32'h5; rs2_2 = 5'd6; rdat2_2 = 32'h66; #1;
    chk("fwd1", 64'(fwd1_2), 64'h18);
    chk("fwd2", 64'(fwd2_2), 64'h66);
`endif
    @(negedge clk);
    valid_4 = 0; reg_wr_4 = 0; rd_4 = 0; wb_sel_4 = 0; alu_res_4 = 0; stall_i = 0;
    chk("pre.wr", 64'(wr_5), 1);
    #1 rst = 1'b1; #1;
    chk("arst.valid", 64'(valid_5), 0); chk("arst.wr", 64'(wr_5), 0);
    chk("arst.data", 64'(write_data_5), 0); chk("arst.cnt", 64'(retire_cnt), 0);
    #1 rst = 1'b0;
    cyc("post",  0, 0, 1, 1, 5, 2'b00, 3'b000, 0, 32'hA,       32'h0,        32'h0,    1, 1, 5, 32'hA,        0, 1, 1);
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin @(posedge clk); #2; wait_cyc++; end
    if (q.size() > 0) chk("drain2", 64'(q.size()), 0);
`ifdef WB_BYPASS_EN
    rs1_2 = 5'd5; rdat1_2 = 32'h5; rs2_2 = 5'd6; rdat2_2 = 32'h66; #1;
    chk("fwd1b", 64'(fwd1_2), 64'hA);
    chk("fwd2b", 64'(fwd2_2), 64'h66);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
